axi4_lite_reg_master: RTL and testbench

//   Command-driven AXI4-lite master (initiator): turns single register read/write

---
 rtl/axi4_lite_reg_master.sv | 161 ++++++++++++++++
 tb/tb_axi4_lite_reg_master.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_reg_master.sv
// Command-driven AXI4-lite master: one register read or write per command, one outstanding.
// Misaligned commands can be rejected locally with SLVERR and never reach the bus.
`timescale 1ns/1ps
module axi4_lite_reg_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter bit          CHECK_ALIGN    = 1'b1,
    localparam int unsigned STRB_WIDTH    = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [AXI_ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]                awprot,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [AXI_DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0]     wstrb,
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [2:0]                arprot,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [AXI_DATA_WIDTH-1:0] rdata,
    input  logic [1:0]                rresp,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0] i_cmd_wdata,
    input  logic [STRB_WIDTH-1:0]     i_cmd_wstrb,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]                o_rsp_resp,
    output logic                      o_busy
);
    localparam int unsigned ALIGN_BITS = $clog2(STRB_WIDTH);
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     wstrb_q;
    logic                      misaligned;

    assign misaligned  = CHECK_ALIGN && (i_cmd_addr[ALIGN_BITS-1:0] != '0);
    assign o_cmd_ready = (state == IDLE);

    // Address/data come straight from the captured command so they stay stable under valid.
    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign awprot = 3'b000;
    assign arprot = 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_resp  <= 2'b00;
            o_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        addr_q  <= i_cmd_addr;
                        wdata_q <= i_cmd_wdata;
                        wstrb_q <= i_cmd_wstrb;
                        o_busy  <= 1'b1;
                        if (misaligned) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_rdata <= '0;
                            o_rsp_resp  <= RESP_SLVERR;
                            state       <= RESP;
                        end else if (i_cmd_write) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    // AW and W retire independently; leave once neither is still pending.
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready      <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= '0;
                        o_rsp_resp  <= bresp;
                        state       <= RESP;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready      <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= rdata;
                        o_rsp_resp  <= rresp;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_reg_master.sv
// Bench for axi4_lite_reg_master: 16-register AXI4-lite slave with programmable waits,
// directed scenarios, then random commands checked against a register-map model.
`timescale 1ns/1ps
module tb_axi4_lite_reg_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;
    logic        i_cmd_valid = 1'b0, i_cmd_write = 1'b0, i_rsp_ready = 1'b0;
    logic [31:0] i_cmd_addr = '0, i_cmd_wdata = '0;
    logic [3:0]  i_cmd_wstrb = '0;
    logic        o_cmd_ready, o_rsp_valid, o_busy;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;

    int checks = 0;
    int failures = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

    always #5 clk = ~clk;

    axi4_lite_reg_master dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp(o_rsp_resp), .o_busy(o_busy)
    );

    // Slave: 16 words at 0x00-0x3C, SLVERR above; ready asserted after N valid cycles.
    logic        aw_got, w_got, ar_got;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [16] = '{default: 32'h0};

    assign awready = !aw_got && (aw_cnt >= aw_wait);
    assign wready  = !w_got && (w_cnt >= w_wait);
    assign arready = !ar_got && (ar_cnt >= ar_wait);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            s_awaddr <= '0; s_wdata <= '0; s_araddr <= '0; s_wstrb <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1'b1; s_awaddr <= awaddr;
            end else if (awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin
                w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb;
            end else if (wvalid && !w_got) w_cnt <= w_cnt + 1;
            if (aw_got && w_got && !bvalid) begin
                if (b_cnt >= b_wait) begin
                    bvalid <= 1'b1;
                    if (s_awaddr < 32'd64) begin
                        for (int i = 0; i < 4; i++)
                            if (s_wstrb[i]) mem[s_awaddr[5:2]][8*i +: 8] <= s_wdata[8*i +: 8];
                        bresp <= 2'b00;
                    end else bresp <= 2'b10;
                end else b_cnt <= b_cnt + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
                aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            end
            if (arvalid && arready) begin
                ar_got <= 1'b1; s_araddr <= araddr;
            end else if (arvalid && !ar_got) ar_cnt <= ar_cnt + 1;
            if (ar_got && !rvalid) begin
                if (r_cnt >= r_wait) begin
                    rvalid <= 1'b1;
                    if (s_araddr < 32'd64) begin
                        rdata <= mem[s_araddr[5:2]]; rresp <= 2'b00;
                    end else begin
                        rdata <= '0; rresp <= 2'b10;
                    end
                end else r_cnt <= r_cnt + 1;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_got <= 1'b0; ar_cnt <= 0; r_cnt <= 0;
            end
        end
    end

    // Bus monitor: valid-high cycle counts, B handshakes and AXI stability violations.
    int          aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0, proto_err = 0;
    logic        p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    always @(posedge clk) begin
        if (awvalid) aw_hi = aw_hi + 1;
        if (wvalid) w_hi = w_hi + 1;
        if (arvalid) ar_hi = ar_hi + 1;
        if (bvalid && bready) b_hs = b_hs + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
            p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0; p_wstrb <= '0;
        end else begin
            if (p_aw && !(awvalid && awaddr == p_awaddr)) proto_err = proto_err + 1;
            if (p_w && !(wvalid && wdata == p_wdata && wstrb == p_wstrb)) proto_err = proto_err + 1;
            if (p_ar && !(arvalid && araddr == p_araddr)) proto_err = proto_err + 1;
            if (awprot != 3'b000 || arprot != 3'b000) proto_err = proto_err + 1;
            p_aw <= awvalid && !awready; p_awaddr <= awaddr;
            p_w  <= wvalid && !wready;   p_wdata <= wdata; p_wstrb <= wstrb;
            p_ar <= arvalid && !arready; p_araddr <= araddr;
        end
    end

    // Register-map reference: aligned 0x00-0x3C is RAM with byte strobes, all else errors.
    logic [31:0] ref_mem [16] = '{default: 32'h0};

    task automatic ref_model(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] er, output logic [31:0] ed);
        if ((a % 32'd4) != 32'd0 || a >= 32'd64) begin
            er = 2'b10; ed = 32'h0;
        end else if (w) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[a[5:2]][8*i +: 8] = d[8*i +: 8];
            er = 2'b00; ed = 32'h0;
        end else begin
            er = 2'b00; ed = ref_mem[a[5:2]];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_addr = a; i_cmd_wdata = d; i_cmd_wstrb = s;
        while (o_cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        chk("cmd_accept_timeout", 64'(n < 100), 64'd1);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [1:0] er, input logic [31:0] ed,
                            input int hold);
        int n = 0;
        while (o_rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        chk({tag, "_rsp_timeout"}, 64'(n < 200), 64'd1);
        chk({tag, "_resp"}, 64'(o_rsp_resp), 64'(er));
        chk({tag, "_rdata"}, 64'(o_rsp_rdata), 64'(ed));
        repeat (hold) @(negedge clk);
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  er;
        logic [31:0] ed, a, d;
        logic [3:0]  s;
        logic        w;
        int          aw0, w0, ar0, b0, bad, n;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, o_rsp_valid}), 64'd0);
        chk("rst_rsp", 64'({o_rsp_resp, o_rsp_rdata}), 64'd0);
        rst_n = 1'b1;

        // Write then read back a register.
        ref_model(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, er, ed);
        send_cmd(1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
        chk("wr_busy", 64'(o_busy), 64'd1);
        wait_rsp("t1_wr", 2'b00, 32'h0, 0);
        ref_model(1'b0, 32'h8, 32'h0, 4'h0, er, ed);
        send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
        wait_rsp("t1_rd", 2'b00, 32'hDEADBEEF, 0);

        // AW stalled 5 cycles while W is taken at once.
        aw_wait = 5; aw0 = aw_hi; w0 = w_hi; b0 = b_hs;
        ref_model(1'b1, 32'h4, 32'hA5A5_0F0F, 4'h5, er, ed);
        send_cmd(1'b1, 32'h4, 32'hA5A5_0F0F, 4'h5);
        wait_rsp("t2_wr", er, ed, 0);
        chk("t2_aw_cycles", 64'(aw_hi - aw0), 64'd6);
        chk("t2_w_cycles", 64'(w_hi - w0), 64'd1);
        chk("t2_b_count", 64'(b_hs - b0), 64'd1);
        aw_wait = 0;
        ref_model(1'b0, 32'h4, 32'h0, 4'h0, er, ed);
        send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
        wait_rsp("t2_rd", er, ed, 0);

        // Misaligned read is rejected locally without touching the bus.
        ar0 = ar_hi; aw0 = aw_hi;
        send_cmd(1'b0, 32'h6, 32'h0, 4'h0);
        chk("t3_rsp_next_cycle", 64'(o_rsp_valid), 64'd1);
        wait_rsp("t3", 2'b10, 32'h0, 0);
        chk("t3_no_bus", 64'((ar_hi - ar0) + (aw_hi - aw0)), 64'd0);

        // Response held back; a new command must wait for the response handshake.
        ref_model(1'b1, 32'h20, 32'h1234_5678, 4'hF, er, ed);
        send_cmd(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        n = 0;
        while (o_rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 32'h20;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b1 || o_rsp_resp !== 2'b00 || o_rsp_rdata !== 32'h0 ||
                o_cmd_ready !== 1'b0 || o_busy !== 1'b1) bad++;
        end
        chk("t4_held_bad_cycles", 64'(bad), 64'd0);
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        chk("t4_rsp_dropped", 64'(o_rsp_valid), 64'd0);
        @(negedge clk);
        chk("t4_ready_after_hs", 64'(o_cmd_ready), 64'd1);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        chk("t4_accepted", 64'(o_busy), 64'd1);
        ref_model(1'b0, 32'h20, 32'h0, 4'h0, er, ed);
        wait_rsp("t4_rd", er, ed, 0);

        // Slave error on an unmapped address is passed through.
        ref_model(1'b0, 32'h100, 32'h0, 4'h0, er, ed);
        send_cmd(1'b0, 32'h100, 32'h0, 4'h0);
        wait_rsp("t5", er, ed, 0);
        chk("t5_resp_const", 64'(o_rsp_resp), 64'd2);

        // Reset while AR is pending abandons the read.
        ar_wait = 20;
        send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
        n = 0;
        while (arvalid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        chk("t6_arvalid_seen", 64'(arvalid), 64'd1);
        rst_n = 1'b0; #1;
        chk("t6_arvalid_drop", 64'(arvalid), 64'd0);
        chk("t6_busy_rst", 64'(o_busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; ar_wait = 0;
        @(negedge clk);
        chk("t6_ready_after", 64'({o_cmd_ready, o_busy}), 64'b10);
        ref_model(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, er, ed);
        send_cmd(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF);
        wait_rsp("t6_wr", er, ed, 0);
        ref_model(1'b0, 32'h10, 32'h0, 4'h0, er, ed);
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp("t6_rd", er, ed, 0);

        // Random commands over mapped, unmapped and misaligned addresses.
        for (int k = 0; k < 60; k++) begin
            aw_wait = int'($urandom_range(0, 3)); w_wait = int'($urandom_range(0, 3));
            b_wait  = int'($urandom_range(0, 2)); ar_wait = int'($urandom_range(0, 3));
            r_wait  = int'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15)) * 32'd4;
            n = int'($urandom_range(0, 9));
            if (n == 0) a = a + 32'($urandom_range(1, 3));
            if (n == 1) a = a + 32'h100;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            ref_model(w, a, d, s, er, ed);
            send_cmd(w, a, d, s);
            wait_rsp("rnd", er, ed, int'($urandom_range(0, 2)));
        end

        chk("protocol_violations", 64'(proto_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
